// File: rtl/sequenciador_servo_pkg.sv
// rtl/sequenciador_servo_pkg.sv - shared encodings and defaults for the servo sweep sequencer
package sequenciador_servo_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        CARREGA = 2'b01,
        ESPERA  = 2'b10,
        AVANCA  = 2'b11
    } estado_t;

    typedef enum logic {
        DESCE = 1'b0,
        SOBE  = 1'b1
    } direcao_t;

    localparam int DWELL_CYCLES_PADRAO = 50000000;
    localparam int POS_MAX_PADRAO      = 7;

endpackage

// File: rtl/sequenciador_servo_contador_dwell.sv
// rtl/sequenciador_servo_contador_dwell.sv - dwell counter, flags the last cycle of a position dwell
module contador_dwell
    import sequenciador_servo_pkg::*;
#(
    parameter int DWELL_CYCLES = DWELL_CYCLES_PADRAO
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int            LARGURA = $clog2(DWELL_CYCLES);
    localparam logic [LARGURA-1:0] ULTIMO = LARGURA'(DWELL_CYCLES - 1);

    logic [LARGURA-1:0] contagem;

    // Saturates at the last value so the count can never leave 0..DWELL_CYCLES-1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            contagem <= '0;
        end else if (zera) begin
            contagem <= '0;
        end else if (conta && (contagem != ULTIMO)) begin
            contagem <= contagem + 1'b1;
        end
    end

    assign fim = (contagem == ULTIMO);

endmodule

// File: rtl/sequenciador_servo.sv
// rtl/sequenciador_servo.sv - sweeps the servo position code 0..POS_MAX..0 with a fixed dwell per step
module sequenciador_servo
    import sequenciador_servo_pkg::*;
#(
    parameter int DWELL_CYCLES = DWELL_CYCLES_PADRAO,
    parameter int POS_MAX      = POS_MAX_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       parar,
    input  logic       continuo,
    output logic [2:0] posicao,
    output logic       ativo,
    output logic       fim_ciclo,
    output logic [1:0] db_estado
);

    localparam logic [2:0] POS_TOPO = 3'(POS_MAX);

    estado_t    estado, estado_prox;
    direcao_t   direcao, direcao_prox;
    logic [2:0] posicao_prox;
    logic       fim_dwell;
    logic       conta;

    assign conta = (estado == ESPERA);

    contador_dwell #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_contador_dwell (
        .clock(clock),
        .reset(reset),
        .zera (!conta),
        .conta(conta),
        .fim  (fim_dwell)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado  <= OCIOSO;
            posicao <= '0;
            direcao <= SOBE;
        end else begin
            estado  <= estado_prox;
            posicao <= posicao_prox;
            direcao <= direcao_prox;
        end
    end

    always_comb begin
        estado_prox  = estado;
        posicao_prox = posicao;
        direcao_prox = direcao;
        fim_ciclo    = 1'b0;

        // A stop freezes posicao where it is and suppresses the end-of-sweep pulse.
        if ((estado != OCIOSO) && parar) begin
            estado_prox = OCIOSO;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (iniciar && !parar) begin
                        estado_prox  = CARREGA;
                        posicao_prox = '0;
                        direcao_prox = SOBE;
                    end
                end
                CARREGA: begin
                    posicao_prox = '0;
                    direcao_prox = SOBE;
                    estado_prox  = ESPERA;
                end
                ESPERA: begin
                    if (fim_dwell) begin
                        estado_prox = AVANCA;
                    end
                end
                AVANCA: begin
                    estado_prox = ESPERA;
                    if (direcao == SOBE) begin
                        if (posicao < POS_TOPO) begin
                            posicao_prox = posicao + 3'd1;
                        end else begin
                            direcao_prox = DESCE;
                            if (posicao != 3'd0) begin
                                posicao_prox = posicao - 3'd1;
                            end
                        end
                    end else if (posicao != 3'd0) begin
                        posicao_prox = posicao - 3'd1;
                    end else begin
                        fim_ciclo = 1'b1;
                        if (continuo) begin
                            direcao_prox = SOBE;
                            posicao_prox = 3'd1;
                        end else begin
                            estado_prox  = OCIOSO;
                            posicao_prox = '0;
                        end
                    end
                end
                default: estado_prox = OCIOSO;
            endcase
        end
    end

    assign ativo     = (estado != OCIOSO);
    assign db_estado = estado;

endmodule

// File: tb/tb_sequenciador_servo.sv
// tb/tb_sequenciador_servo.sv - self-checking bench for sequenciador_servo (DWELL_CYCLES=4, POS_MAX=7)
module tb_sequenciador_servo;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       parar;
    logic       continuo;
    logic [2:0] posicao;
    logic       ativo;
    logic       fim_ciclo;
    logic [1:0] db_estado;

    int n_total = 0;
    int n_pass  = 0;

    sequenciador_servo #(
        .DWELL_CYCLES(4),
        .POS_MAX     (7)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .parar    (parar),
        .continuo (continuo),
        .posicao  (posicao),
        .ativo    (ativo),
        .fim_ciclo(fim_ciclo),
        .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       iniciar;
        logic       parar;
        logic       continuo;
        logic [1:0] est;
        logic [2:0] pos;
        logic       ativo;
        logic       fim;
    } vetor_t;

    vetor_t tab[18];

    task automatic chk(input string nome, input int atual, input int esperado);
        n_total++;
        if (atual == esperado) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0d, expected %0d", nome, $time, atual, esperado);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_saidas(input string nome, input int est, input int pos, input int atv, input int fim);
        chk({nome, ".db_estado"}, int'(db_estado), est);
        chk({nome, ".posicao"},   int'(posicao),   pos);
        chk({nome, ".ativo"},     int'(ativo),     atv);
        chk({nome, ".fim_ciclo"}, int'(fim_ciclo), fim);
    endtask

    task automatic do_reset();
        iniciar  = 1'b0;
        parar    = 1'b0;
        continuo = 1'b0;
        reset    = 1'b0;
        step();
        step();
        reset    = 1'b1;
        step();
    endtask

    task automatic espera_pos(input logic [2:0] alvo);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (posicao == alvo && db_estado == 2'b10) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        chk("espera_pos_timeout", int'(ok), 1);
    endtask

    // Expected sweep timeline: first 0 for 6 cycles, every later value for 5.
    task automatic run_sweep(input bit pulsar, input string nome);
        int exp_pos[$];
        exp_pos = {};
        for (int i = 0; i < 6; i++) exp_pos.push_back(0);
        for (int v = 1; v <= 7; v++) for (int i = 0; i < 5; i++) exp_pos.push_back(v);
        for (int v = 6; v >= 0; v--) for (int i = 0; i < 5; i++) exp_pos.push_back(v);

        continuo = 1'b0;
        iniciar  = 1'b1;
        step();
        for (int k = 0; k < exp_pos.size(); k++) begin
            chk({nome, ".posicao"},   int'(posicao),   exp_pos[k]);
            chk({nome, ".fim_ciclo"}, int'(fim_ciclo), (k == exp_pos.size() - 1) ? 1 : 0);
            chk({nome, ".ativo"},     int'(ativo),     1);
            if (k < exp_pos.size() - 1) begin
                iniciar = pulsar && ((k % 3) == 0);
                step();
            end
        end
        iniciar = 1'b0;
        step();
        chk_saidas({nome, ".apos"}, 0, 0, 0, 0);
    endtask

    initial begin
        int n;

        iniciar  = 1'b0;
        parar    = 1'b0;
        continuo = 1'b0;
        reset    = 1'b0;
        #2;
        chk_saidas("reset_inicial", 0, 0, 0, 0);
        step();
        reset = 1'b1;
        step();

        //                  ini   par   cont  est    pos   atv   fim
        tab[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0};
        tab[1]  = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0};
        tab[2]  = '{1'b1, 1'b0, 1'b0, 2'd1, 3'd0, 1'b1, 1'b0};
        tab[3]  = '{1'b0, 1'b0, 1'b0, 2'd2, 3'd0, 1'b1, 1'b0};
        tab[4]  = '{1'b1, 1'b0, 1'b0, 2'd2, 3'd0, 1'b1, 1'b0};
        tab[5]  = '{1'b0, 1'b0, 1'b0, 2'd2, 3'd0, 1'b1, 1'b0};
        tab[6]  = '{1'b0, 1'b0, 1'b0, 2'd2, 3'd0, 1'b1, 1'b0};
        tab[7]  = '{1'b0, 1'b0, 1'b0, 2'd3, 3'd0, 1'b1, 1'b0};
        tab[8]  = '{1'b0, 1'b0, 1'b0, 2'd2, 3'd1, 1'b1, 1'b0};
        tab[9]  = '{1'b0, 1'b0, 1'b0, 2'd2, 3'd1, 1'b1, 1'b0};
        tab[10] = '{1'b0, 1'b0, 1'b0, 2'd2, 3'd1, 1'b1, 1'b0};
        tab[11] = '{1'b0, 1'b0, 1'b0, 2'd2, 3'd1, 1'b1, 1'b0};
        tab[12] = '{1'b0, 1'b0, 1'b0, 2'd3, 3'd1, 1'b1, 1'b0};
        tab[13] = '{1'b0, 1'b0, 1'b0, 2'd2, 3'd2, 1'b1, 1'b0};
        tab[14] = '{1'b1, 1'b1, 1'b0, 2'd0, 3'd2, 1'b0, 1'b0};
        tab[15] = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 1'b0, 1'b0};
        tab[16] = '{1'b1, 1'b0, 1'b0, 2'd1, 3'd0, 1'b1, 1'b0};
        tab[17] = '{1'b0, 1'b0, 1'b0, 2'd2, 3'd0, 1'b1, 1'b0};

        for (int i = 0; i < 18; i++) begin
            iniciar  = tab[i].iniciar;
            parar    = tab[i].parar;
            continuo = tab[i].continuo;
            step();
            chk_saidas($sformatf("tab%0d", i), int'(tab[i].est), int'(tab[i].pos),
                       int'(tab[i].ativo), int'(tab[i].fim));
        end

        do_reset();
        run_sweep(1'b0, "varredura_simples");
        run_sweep(1'b1, "varredura_pulsos");

        // Continuous sweep: no idle visit after fim_ciclo, 70 cycles between pulses.
        do_reset();
        continuo = 1'b1;
        iniciar  = 1'b1;
        step();
        iniciar  = 1'b0;
        n = 0;
        while (!fim_ciclo && n < 200) begin
            step();
            n++;
        end
        chk("continuo.primeiro_fim", int'(fim_ciclo), 1);
        step();
        chk_saidas("continuo.apos_fim", 2, 1, 1, 0);
        n = 1;
        while (!fim_ciclo && n < 200) begin
            step();
            n++;
        end
        chk("continuo.intervalo", n, 70);
        parar = 1'b1;
        step();
        parar = 1'b0;
        chk_saidas("continuo.parado", 0, 0, 0, 0);

        // Stop at position 5 on the way up, then restart from 0.
        do_reset();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        espera_pos(3'd5);
        parar = 1'b1;
        step();
        parar = 1'b0;
        chk_saidas("parar5", 0, 5, 0, 0);
        step();
        step();
        chk_saidas("parar5.segura", 0, 5, 0, 0);
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        chk_saidas("parar5.reinicio", 1, 0, 1, 0);
        step();
        chk_saidas("parar5.espera", 2, 0, 1, 0);

        // Asynchronous reset mid-ESPERA at position 3.
        do_reset();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        espera_pos(3'd3);
        #2;
        reset = 1'b0;
        #1;
        chk_saidas("reset_assincrono", 0, 0, 0, 0);
        step();
        reset = 1'b1;
        step();
        step();
        step();
        chk_saidas("apos_reset", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
